// File: rtl/riscv_mc_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes, FSM states
// and the datapath mux-select encodings driven by riscv_mc_control.
package riscv_mc_control_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC_R,
      ST_EXEC_I,
      ST_ALU_WB,
      ST_MEM_ADDR,
      ST_MEM_RD,
      ST_MEM_WB,
      ST_MEM_WR,
      ST_BRANCH,
      ST_JAL,
      ST_JALR,
      ST_LUI,
      ST_HALT,
      ST_ERR
   } state_e;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JALR   = 2'd2;

   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_OLDPC = 2'd1;
   localparam logic [1:0] SRC_A_RS1   = 2'd2;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_FOUR = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;

   localparam logic [1:0] ALU_OP_ADD   = 2'd0;
   localparam logic [1:0] ALU_OP_SUB   = 2'd1;
   localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;
   localparam logic [1:0] WB_IMM    = 2'd3;

   // States that own the unified memory port and are watched by the timeout counter.
   function automatic logic is_mem_state(input state_e s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/riscv_mc_control.sv
// Multi-cycle main control FSM for the RV32I core: sequences fetch/decode/execute/
// mem/writeback, owns the memory handshake, the wait watchdog and the halt/error states.
module riscv_mc_control
   import riscv_mc_control_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       br_taken,
   input  logic       mem_ready,
   input  logic       halt_req,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       halted,
   output logic       error
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       halt_take;
   logic       mem_busy;
   logic       timeout;

   // A halt is only honoured before the fetch access has started waiting, so an
   // issued mem_req is never withdrawn before mem_ready.
   assign halt_take = (state_q == ST_FETCH) && halt_req && (wait_cnt_q == 8'd0);
   assign mem_busy  = is_mem_state(state_q) && !halt_take;
   assign timeout   = mem_busy && !mem_ready && (wait_cnt_q == WAIT_LIMIT);

   // NOTE: every signal written in an always_comb gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (halt_take)      state_d = ST_HALT;
            else if (mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (opcode)
               OP_R:           state_d = ST_EXEC_R;
               OP_I:           state_d = ST_EXEC_I;
               OP_LOAD, OP_S:  state_d = ST_MEM_ADDR;
               OP_B:           state_d = ST_BRANCH;
               OP_JAL:         state_d = ST_JAL;
               OP_JALR:        state_d = ST_JALR;
               OP_LUI:         state_d = ST_LUI;
               OP_AUIPC:       state_d = ST_ALU_WB;
               default:        state_d = ST_ERR;
            endcase
         end
         ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
         ST_MEM_ADDR:          state_d = (opcode == OP_S) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:            if (mem_ready) state_d = ST_MEM_WB;
         ST_MEM_WR:            if (mem_ready) state_d = ST_FETCH;
         ST_HALT:              if (!halt_req) state_d = ST_FETCH;
         ST_ERR:               state_d = ST_ERR;
         default:              state_d = ST_FETCH;
      endcase
      if (timeout) state_d = ST_ERR;

      // Counts consecutive unanswered cycles of one access; any state change clears it.
      if (mem_busy && !mem_ready && (state_d == state_q)) wait_cnt_d = wait_cnt_q + 8'd1;
      else                                                 wait_cnt_d = 8'd0;
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_ALU;
      alu_src_a = SRC_A_PC;
      alu_src_b = SRC_B_RS2;
      alu_op    = ALU_OP_ADD;
      reg_write = 1'b0;
      wb_sel    = WB_ALUOUT;
      halted    = 1'b0;
      error     = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               if (!halt_take) begin
                  mem_req   = 1'b1;
                  alu_src_b = SRC_B_FOUR;
                  if (mem_ready) begin
                     ir_write = 1'b1;
                     pc_write = 1'b1;
                  end
               end
            end
            ST_DECODE: begin
               alu_src_a = SRC_A_OLDPC;
               alu_src_b = SRC_B_IMM;
            end
            ST_EXEC_R: begin
               alu_src_a = SRC_A_RS1;
               alu_op    = ALU_OP_FUNCT;
            end
            ST_EXEC_I: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_OP_FUNCT;
            end
            ST_ALU_WB: reg_write = 1'b1;
            ST_MEM_ADDR: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            ST_MEM_WB: begin
               reg_write = 1'b1;
               wb_sel    = WB_MDR;
            end
            ST_MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
            end
            ST_BRANCH: begin
               alu_src_a = SRC_A_RS1;
               alu_op    = ALU_OP_SUB;
               pc_write  = br_taken;
               pc_src    = PC_SRC_ALUOUT;
            end
            ST_JAL: begin
               pc_write  = 1'b1;
               pc_src    = PC_SRC_ALUOUT;
               reg_write = 1'b1;
               wb_sel    = WB_PC;
            end
            ST_JALR: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               pc_write  = 1'b1;
               pc_src    = PC_SRC_JALR;
               reg_write = 1'b1;
               wb_sel    = WB_PC;
            end
            ST_LUI: begin
               reg_write = 1'b1;
               wb_sel    = WB_IMM;
            end
            ST_HALT: halted = 1'b1;
            ST_ERR:  error  = 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule
